// File: rtl/prog_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_ctrl_if
// Brief    : UART, CPU memory and BRAM port A signal bundle for the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_ctrl_if #(
    parameter int AW = 11
);
    logic [7:0]    rx_data;
    logic          rx_data_wr;
    logic [AW-1:0] cpu_mem_addr;
    logic          cpu_mem_wr;
    logic [15:0]   cpu_wr_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wr_data;
    logic          cpu_rst;
    logic [15:0]   uart_in;
    logic          uart_in_v;
    logic          load_err;
    logic [AW-1:0] load_addr;

    // Environment side: UART and CPU drive, BRAM/CPU observe.
    modport master (
        output rx_data, rx_data_wr, cpu_mem_addr, cpu_mem_wr, cpu_wr_data,
        input  mem_wr, mem_addr, mem_wr_data, cpu_rst, uart_in, uart_in_v,
               load_err, load_addr
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_data_wr, cpu_mem_addr, cpu_mem_wr, cpu_wr_data,
        output mem_wr, mem_addr, mem_wr_data, cpu_rst, uart_in, uart_in_v,
               load_err, load_addr
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_ctrl
// Brief    : Pairs UART bytes into words, loads them into BRAM port A, then
//            releases the CPU and forwards later UART words to it.
//            Optional checksum word after the end marker: LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader_ctrl #(
    parameter int            AW         = 11,
    parameter logic [AW-1:0] LOAD_BASE  = 11'h200,
    parameter logic [AW-1:0] LOAD_LIMIT = 11'h7FE,
    parameter int            TIMEOUT    = 27000
) (
    input  wire logic         sys_clk,
    input  wire logic         rst_n,
    prog_loader_ctrl_if.slave bus
);

    localparam int                c_CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [15:0]       c_END_MARK = 16'hFFFF;
    localparam logic [15:0]       c_RELOAD   = 16'hFFFE;

    typedef enum logic [2:0] {
        LD_HI = 3'd0,
        LD_LO = 3'd1,
        LD_WR = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        LD_CK = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     word_q, word_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   load_addr_q, load_addr_d;
    logic            load_err_q, load_err_d;
    logic [15:0]     uart_in_q, uart_in_d;
    logic            uart_in_v_q, uart_in_v_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]     sum_q, sum_d;
`endif

    logic        w_rx_ok;
    logic        w_done;
    logic        w_expire;
    logic        w_reload;
    logic [15:0] w_word;

    // pend_q marks a high byte waiting for its partner in every state; in the
    // load phase it mirrors LD_LO, elsewhere it is the only pairing state.
    assign w_rx_ok  = bus.rx_data_wr && (state_q != LD_WR);
    assign w_word   = {hi_q, bus.rx_data};
    assign w_done   = w_rx_ok && pend_q;
    assign w_expire = pend_q && !bus.rx_data_wr && (cnt_q == c_CNT_LAST);
    assign w_reload = w_done && (w_word == c_RELOAD) &&
                      ((state_q == RUN) || (state_q == ERR));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_HI;
            hi_q        <= 8'h00;
            word_q      <= 16'h0000;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            load_addr_q <= LOAD_BASE;
            load_err_q  <= 1'b0;
            uart_in_q   <= 16'h0000;
            uart_in_v_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            load_addr_q <= load_addr_d;
            load_err_q  <= load_err_d;
            uart_in_q   <= uart_in_d;
            uart_in_v_q <= uart_in_v_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        load_addr_d = load_addr_q;
        load_err_d  = load_err_q;
        uart_in_d   = uart_in_q;
        uart_in_v_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        // Byte pairing with hi/lo timeout; a strobe on the expiry cycle wins.
        if (w_rx_ok && !pend_q) begin
            hi_d   = bus.rx_data;
            cnt_d  = '0;
            pend_d = 1'b1;
        end else if (w_done) begin
            pend_d = 1'b0;
        end else if (pend_q) begin
            if (cnt_q == c_CNT_LAST) begin
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + c_CW'(1);
            end
        end

        case (state_q)
            LD_HI: begin
                if (w_rx_ok) begin
                    state_d = LD_LO;
                end
            end
            LD_LO: begin
                if (w_done) begin
                    if (w_word == c_END_MARK) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = LD_CK;
`else
                        state_d = RUN;
`endif
                    end else begin
                        word_d  = w_word;
                        state_d = LD_WR;
                    end
                end else if (w_expire) begin
                    state_d = LD_HI;
                end
            end
            LD_WR: begin
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + word_q;
`endif
                if (load_addr_q == LOAD_LIMIT) begin
                    load_err_d = 1'b1;
                    state_d    = ERR;
                end else begin
                    load_addr_d = load_addr_q + AW'(2);
                    state_d     = LD_HI;
                end
            end
            RUN: begin
                if (w_done && (w_word != c_RELOAD)) begin
                    uart_in_d   = w_word;
                    uart_in_v_d = 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CK: begin
                if (w_done) begin
                    if (w_word == sum_q) begin
                        state_d = RUN;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end
`endif
            default: begin
                state_d = LD_HI;
            end
        endcase

        if (w_reload) begin
            state_d     = LD_HI;
            load_addr_d = LOAD_BASE;
            load_err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_d       = 16'h0000;
`endif
        end
    end

    // Port A belongs to the CPU only in RUN; otherwise only LD_WR writes.
    assign bus.mem_wr      = (state_q == RUN) ? bus.cpu_mem_wr   : (state_q == LD_WR);
    assign bus.mem_addr    = (state_q == RUN) ? bus.cpu_mem_addr : load_addr_q;
    assign bus.mem_wr_data = (state_q == RUN) ? bus.cpu_wr_data  : word_q;
    assign bus.cpu_rst     = (state_q != RUN);
    assign bus.uart_in     = uart_in_q;
    assign bus.uart_in_v   = uart_in_v_q;
    assign bus.load_err    = load_err_q;
    assign bus.load_addr   = load_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader_ctrl
// Brief    : Directed scoreboard bench for prog_loader_ctrl (LOAD_LIMIT=0x204).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader_ctrl;

    localparam int c_TIMEOUT = 27000;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    wr_t         exp_wr[$];
    logic [15:0] exp_uart[$];

    prog_loader_ctrl_if #(.AW(11)) bus ();

    prog_loader_ctrl #(
        .AW         (11),
        .LOAD_BASE  (11'h200),
        .LOAD_LIMIT (11'h204),
        .TIMEOUT    (c_TIMEOUT)
    ) u_dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every BRAM write and every uart_in_v pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr) begin
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                             bus.mem_addr, bus.mem_wr_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_wr_data !== e.data) begin
                        n_errors++;
                        $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                                 bus.mem_addr, bus.mem_wr_data, e.addr, e.data);
                    end
                end
            end
            if (bus.uart_in_v) begin
                n_checks++;
                if (exp_uart.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_uart_in: got %h, expected no pulse", bus.uart_in);
                end else begin
                    logic [15:0] u;
                    u = exp_uart.pop_front();
                    if (bus.uart_in !== u) begin
                        n_errors++;
                        $display("FAIL uart_in: got %h, expected %h", bus.uart_in, u);
                    end
                end
            end
        end
    end

    // Returns just after the clock edge that sampled the strobe.
    task automatic send_byte(input logic [7:0] b, input int gap = 2);
        repeat (gap) @(posedge clk);
        #1;
        bus.rx_data    = b;
        bus.rx_data_wr = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_data_wr = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic push_wr(input logic [10:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic finish_load(input logic [15:0] sum);
        send_word(16'hFFFF);
`ifdef LOADER_CHECKSUM_EN
        send_word(sum);
`else
        sum = sum;
`endif
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.cpu_mem_addr = a;
        bus.cpu_wr_data  = d;
        bus.cpu_mem_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_mem_wr   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_load_addr", 32'(bus.load_addr), 32'h200);
        check("async_reset_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_data_wr   = 1'b0;
        bus.cpu_mem_addr = 11'h000;
        bus.cpu_mem_wr   = 1'b0;
        bus.cpu_wr_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        check("reset_mem_wr", 32'(bus.mem_wr), 32'h0);
        check("reset_load_addr", 32'(bus.load_addr), 32'h200);
        check("reset_load_err", 32'(bus.load_err), 32'h0);
        check("reset_uart_in", 32'(bus.uart_in), 32'h0);
        check("reset_uart_in_v", 32'(bus.uart_in_v), 32'h0);
        rst_n = 1'b1;

        // CPU writes outside RUN must not reach port A.
        cpu_write(11'h100, 16'hDEAD);

        // Basic load: two words then end marker.
        push_wr(11'h200, 16'h1234);
        push_wr(11'h202, 16'h5678);
        send_byte(8'h12);
        send_byte(8'h34);
        check("write_latency_mem_wr", 32'(bus.mem_wr), 32'h1);
        send_word(16'h5678);
        repeat (3) @(posedge clk);
        #1;
        check("load_cpu_rst_held", 32'(bus.cpu_rst), 32'h1);
        finish_load(16'h68AC);
        check("run_cpu_rst_released", 32'(bus.cpu_rst), 32'h0);
        check("run_load_addr", 32'(bus.load_addr), 32'h204);
        check("run_load_err", 32'(bus.load_err), 32'h0);

        // RUN: combinational CPU pass-through.
        push_wr(11'h100, 16'hBEEF);
        @(posedge clk);
        #1;
        bus.cpu_mem_addr = 11'h100;
        bus.cpu_wr_data  = 16'hBEEF;
        bus.cpu_mem_wr   = 1'b1;
        #1;
        check("passthru_same_cycle", {15'h0, bus.mem_wr, bus.mem_addr[10:0], 5'h0},
              {15'h0, 1'b1, 11'h100, 5'h0});
        @(posedge clk);
        #1;
        bus.cpu_mem_wr = 1'b0;

        // RUN: UART word forwarding.
        exp_uart.push_back(16'hABCD);
        send_word(16'hABCD);
        repeat (3) @(posedge clk);
        #1;
        check("uart_in_value", 32'(bus.uart_in), 32'hABCD);

        // RUN: reload command.
        send_word(16'hFFFE);
        check("reload_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        check("reload_load_addr", 32'(bus.load_addr), 32'h200);
        push_wr(11'h200, 16'h0001);
        send_word(16'h0001);
        repeat (3) @(posedge clk);
        #1;
        check("reload_next_addr", 32'(bus.load_addr), 32'h202);

        // Reset mid-load with a high byte pending.
        send_byte(8'h77);
        pulse_reset();

        // Timeout drops a lone high byte; strobe on the expiry cycle is kept.
        push_wr(11'h200, 16'h3456);
        push_wr(11'h202, 16'h9ABC);
        send_byte(8'h12);
        send_byte(8'h34, 30000);
        send_byte(8'h56);
        send_byte(8'h9A);
        send_byte(8'hBC, c_TIMEOUT - 1);
        finish_load(16'hCF12);
        check("timeout_load_err", 32'(bus.load_err), 32'h0);
        check("timeout_cpu_rst", 32'(bus.cpu_rst), 32'h0);
        check("timeout_load_addr", 32'(bus.load_addr), 32'h204);

        // Load limit: third word lands on LOAD_LIMIT, then ERR.
        send_word(16'hFFFE);
        push_wr(11'h200, 16'h1111);
        push_wr(11'h202, 16'h2222);
        push_wr(11'h204, 16'h3333);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        repeat (2) @(posedge clk);
        #1;
        check("limit_load_err", 32'(bus.load_err), 32'h1);
        check("limit_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        check("limit_no_wrap", 32'(bus.load_addr), 32'h204);
        send_word(16'hFFFF);
        send_word(16'hABCD);
        cpu_write(11'h101, 16'h5555);
        repeat (2) @(posedge clk);
        #1;
        check("err_stays_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        check("err_stays_load_err", 32'(bus.load_err), 32'h1);
        send_word(16'hFFFE);
        check("err_reload_load_err", 32'(bus.load_err), 32'h0);
        check("err_reload_load_addr", 32'(bus.load_addr), 32'h200);
        check("err_reload_cpu_rst", 32'(bus.cpu_rst), 32'h1);

`ifdef LOADER_CHECKSUM_EN
        push_wr(11'h200, 16'h0001);
        push_wr(11'h202, 16'h0002);
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("ck_wait_cpu_rst", 32'(bus.cpu_rst), 32'h1);
        send_word(16'h0003);
        check("ck_match_cpu_rst", 32'(bus.cpu_rst), 32'h0);
        check("ck_match_load_err", 32'(bus.load_err), 32'h0);
        pulse_reset();
        push_wr(11'h200, 16'h0001);
        push_wr(11'h202, 16'h0002);
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'hFFFF);
        send_word(16'h0004);
        check("ck_mismatch_load_err", 32'(bus.load_err), 32'h1);
        check("ck_mismatch_cpu_rst", 32'(bus.cpu_rst), 32'h1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_wr.size()), 32'h0);
        check("pending_uart", 32'(exp_uart.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
